// File: rtl/fb_scaler_fetch.sv
// Display-side pixel fetch: integer-upscales an RGB565 frame buffer into a centred window
// of the 1080p raster and drives RGB888 with de/sync delayed to stay aligned with the pixels.
module fb_scaler_fetch #(
  parameter int          SRC_W  = 320,
  parameter int          SRC_H  = 240,
  parameter int          SCALE  = 4,
  parameter int          WIN_X0 = 320,
  parameter int          WIN_Y0 = 60,
  parameter int          ADDR_W = 17,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       h_cnt,
  input  logic [11:0]       v_cnt,
  input  logic              de_in,
  input  logic              sync_in,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [23:0]       rgb_out,
  output logic              de_out,
  output logic              sync_out
);

  localparam int SX_W = $clog2(SRC_W + 1);

  localparam logic [11:0]       X0        = 12'(WIN_X0);
  localparam logic [11:0]       X1        = 12'(WIN_X0 + SRC_W * SCALE);
  localparam logic [11:0]       Y0        = 12'(WIN_Y0);
  localparam logic [11:0]       Y1        = 12'(WIN_Y0 + SRC_H * SCALE);
  localparam logic [11:0]       Y_ARM     = 12'(WIN_Y0 - 1);
  localparam logic [11:0]       Y_LAST    = 12'(WIN_Y0 + SRC_H * SCALE - 1);
  localparam logic [3:0]        REP_MAX   = 4'(SCALE - 1);
  localparam logic [SX_W-1:0]   SX_LAST   = SX_W'(SRC_W - 1);
  localparam logic [SX_W-1:0]   SX_ONE    = SX_W'(1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);

  function automatic logic [23:0] expand565(input logic [15:0] px);
    return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
  endfunction

  logic              win_h;
  logic              win_v;
  logic              win;
  logic [SX_W-1:0]   src_x;
  logic [3:0]        x_rep;
  logic [ADDR_W-1:0] line_base;
  logic [3:0]        y_rep;
  logic [1:0]        win_d;
  logic [1:0]        de_d;
  logic [1:0]        sync_d;
  logic [23:0]       rgb_next;

  assign win_h = (h_cnt >= X0) && (h_cnt < X1);
  assign win_v = (v_cnt >= Y0) && (v_cnt < Y1);
  assign win   = win_h & win_v & de_in;

  // Horizontal walk: each source pixel is fetched for SCALE consecutive columns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_x   <= '0;
      x_rep   <= 4'd0;
      rd_addr <= '0;
    end else if (win) begin
      rd_addr <= line_base + ADDR_W'(src_x);
      if (x_rep == REP_MAX) begin
        x_rep <= 4'd0;
        // Saturate so the final SCALE columns keep fetching the last source pixel.
        if (src_x != SX_LAST) begin
          src_x <= src_x + SX_ONE;
        end else begin
          src_x <= src_x;
        end
      end else begin
        x_rep <= x_rep + 4'd1;
      end
    end else begin
      src_x <= '0;
      x_rep <= 4'd0;
    end
  end

  // Vertical walk, evaluated once per line at the window exit column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_base <= '0;
      y_rep     <= 4'd0;
    end else if (h_cnt == X1) begin
      if (v_cnt == Y_ARM) begin
        line_base <= '0;
        y_rep     <= 4'd0;
      end else if ((v_cnt >= Y0) && (v_cnt < Y_LAST)) begin
        if (y_rep == REP_MAX) begin
          y_rep     <= 4'd0;
          line_base <= line_base + LINE_STEP;
        end else begin
          y_rep <= y_rep + 4'd1;
        end
      end else begin
        line_base <= line_base;
      end
    end else begin
      line_base <= line_base;
    end
  end

  // Output select: de/win taps have reached the same cycle as rd_data.
  always_comb begin
    rgb_next = 24'h000000;
    if (de_d[1] && win_d[1]) begin
      rgb_next = expand565(rd_data);
    end else if (de_d[1]) begin
      rgb_next = BORDER;
    end else begin
      rgb_next = 24'h000000;
    end
  end

  // Alignment taps and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_d    <= 2'b00;
      de_d     <= 2'b00;
      sync_d   <= 2'b11;
      rgb_out  <= 24'h000000;
      de_out   <= 1'b0;
      sync_out <= 1'b1;
    end else begin
      win_d    <= {win_d[0], win};
      de_d     <= {de_d[0], de_in};
      sync_d   <= {sync_d[0], sync_in};
      rgb_out  <= rgb_next;
      de_out   <= de_d[1];
      sync_out <= sync_d[1];
    end
  end

endmodule

// File: tb/tb_fb_scaler_fetch.sv
// Directed bench for fb_scaler_fetch: frame-buffer RAM model plus an independent
// coordinate-based reference for addresses, pixels and delayed de/sync.
module tb_fb_scaler_fetch;

  localparam logic [23:0] BORDER_C = 24'h102030;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] h_cnt = 12'd0;
  logic [11:0] v_cnt = 12'd0;
  logic        de_in = 1'b0;
  logic        sync_in = 1'b1;
  logic [16:0] rd_addr;
  logic [15:0] rd_data;
  logic [23:0] rgb_out;
  logic        de_out;
  logic        sync_out;

  int vectors = 0;
  int miscompares = 0;
  int ram_mode = 0;

  logic [23:0] e_rgb [3];
  logic        e_de [3];
  logic        e_sync [3];
  logic [16:0] e_addr;

  always #5 clk = ~clk;

  fb_scaler_fetch #(.BORDER(BORDER_C)) dut (
    .clk(clk), .reset(reset), .h_cnt(h_cnt), .v_cnt(v_cnt), .de_in(de_in),
    .sync_in(sync_in), .rd_addr(rd_addr), .rd_data(rd_data), .rgb_out(rgb_out),
    .de_out(de_out), .sync_out(sync_out)
  );

  function automatic logic [15:0] ram_word(input logic [16:0] a);
    if (ram_mode == 1 && a == 17'd0) return 16'hF800;
    return a[15:0];
  endfunction

  // Synchronous frame buffer, one clock of read latency.
  always @(posedge clk) rd_data <= ram_word(rd_addr);

  function automatic logic [23:0] expand(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  function automatic logic [16:0] addr_of(input logic [11:0] h, input logic [11:0] v);
    return 17'(((int'(v) - 60) / 4) * 320 + (int'(h) - 320) / 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      e_rgb[i] = 24'h0; e_de[i] = 1'b0; e_sync[i] = 1'b1;
    end
    e_addr = 17'd0;
  endtask

  // Apply one pixel, step one clock, advance the reference pipeline.
  task automatic cyc(input logic [11:0] h, input logic [11:0] v, input logic de, input logic sy);
    logic w;
    logic [23:0] r;
    h_cnt = h; v_cnt = v; de_in = de; sync_in = sy;
    w = de && h >= 12'd320 && h < 12'd1600 && v >= 12'd60 && v < 12'd1020;
    if (w) e_addr = addr_of(h, v);
    @(posedge clk); #1;
    r = !de ? 24'h0 : (w ? expand(ram_word(e_addr)) : BORDER_C);
    e_rgb[2] = e_rgb[1]; e_rgb[1] = e_rgb[0]; e_rgb[0] = r;
    e_de[2] = e_de[1]; e_de[1] = e_de[0]; e_de[0] = de;
    e_sync[2] = e_sync[1]; e_sync[1] = e_sync[0]; e_sync[0] = sy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      h_cnt = 12'($urandom); v_cnt = 12'($urandom);
      de_in = 1'($urandom); sync_in = 1'($urandom);
      @(posedge clk); #1;
      vectors++;
      if ({rd_addr, rgb_out, de_out, sync_out} !== {17'h0, 24'h0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d: got addr=%h rgb=%h de=%b sync=%b, want 0/0/0/1",
                 i, rd_addr, rgb_out, de_out, sync_out);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_addr_ramp();
    for (int h = 320; h <= 331; h++) cyc(12'(h), 12'd60, 1'b1, 1'b1);
    for (int h = 319; h <= 330; h++) begin
      cyc(12'(h), 12'd60, 1'b1, 1'b1);
      vectors++;
      if (rd_addr !== ((h == 319) ? 17'd2 : 17'((h - 320) / 4))) begin
        miscompares++;
        $display("FAIL ramp_addr h=%0d: got %0d", h, rd_addr);
      end
      vectors++;
      if ({rgb_out, de_out, sync_out} !== {e_rgb[2], e_de[2], e_sync[2]}) begin
        miscompares++;
        $display("FAIL ramp_pipe h=%0d: got %h/%b/%b want %h/%b/%b",
                 h, rgb_out, de_out, sync_out, e_rgb[2], e_de[2], e_sync[2]);
      end
    end
  endtask

  task automatic test_pixel();
    for (int i = 0; i < 3; i++) cyc(12'd0, 12'd60, 1'b0, 1'b1);
    ram_mode = 1;
    cyc(12'd320, 12'd60, 1'b1, 1'b1);
    vectors++;
    if (rd_addr !== 17'd0) begin
      miscompares++; $display("FAIL pixel_addr: got %0d want 0", rd_addr);
    end
    cyc(12'd321, 12'd60, 1'b1, 1'b1);
    vectors++;
    if ({rgb_out, de_out} !== {24'h000000, 1'b0}) begin
      miscompares++; $display("FAIL pixel_early: got %h/%b want 000000/0", rgb_out, de_out);
    end
    cyc(12'd322, 12'd60, 1'b1, 1'b1);
    vectors++;
    if ({rgb_out, de_out} !== {24'hFF0000, 1'b1}) begin
      miscompares++; $display("FAIL pixel_red: got %h/%b want ff0000/1", rgb_out, de_out);
    end
    for (int i = 0; i < 3; i++) cyc(12'd0, 12'd60, 1'b0, 1'b1);
    ram_mode = 0;
  endtask

  task automatic test_frame();
    logic [16:0] base;
    cyc(12'd1600, 12'd59, 1'b0, 1'b1);
    for (int v = 60; v <= 1020; v++) begin
      if (v == 60 || v == 64 || v == 1019 || v == 1020) begin
        base = (v == 64) ? 17'd320 : ((v == 1019) ? 17'd76480 : 17'd0);
        for (int h = 316; h <= 1603; h++) begin
          cyc(12'(h), 12'(v), 1'b1, 1'b1);
          vectors++;
          if (rd_addr !== e_addr || {rgb_out, de_out, sync_out} !== {e_rgb[2], e_de[2], e_sync[2]}) begin
            miscompares++;
            $display("FAIL frame_pix v=%0d h=%0d: got %0d %h/%b/%b want %0d %h/%b/%b", v, h,
                     rd_addr, rgb_out, de_out, sync_out, e_addr, e_rgb[2], e_de[2], e_sync[2]);
          end
          if (v != 1020 && (h == 320 || h == 1599)) begin
            vectors++;
            if (rd_addr !== base + ((h == 1599) ? 17'd319 : 17'd0)) begin
              miscompares++;
              $display("FAIL frame_edge v=%0d h=%0d: got %0d base %0d", v, h, rd_addr, base);
            end
          end
          if (h == 1602 || (v == 1020 && h == 322)) begin
            vectors++;
            if (rgb_out !== BORDER_C) begin
              miscompares++;
              $display("FAIL frame_border v=%0d h=%0d: got %h want %h", v, h, rgb_out, BORDER_C);
            end
          end
        end
      end else begin
        cyc(12'd1600, 12'(v), 1'b0, 1'b1);
        vectors++;
        if (rd_addr !== e_addr || {rgb_out, de_out, sync_out} !== {e_rgb[2], e_de[2], e_sync[2]}) begin
          miscompares++;
          $display("FAIL frame_line v=%0d: got %0d %h/%b/%b", v, rd_addr, rgb_out, de_out, sync_out);
        end
      end
    end
  endtask

  task automatic test_sync();
    int lows = 0;
    int first_h = -1;
    for (int h = 2000; h <= 2063; h++) begin
      cyc(12'(h), 12'd5, 1'b0, !(h >= 2008 && h <= 2051));
      vectors++;
      if ({rgb_out, de_out, sync_out} !== {e_rgb[2], e_de[2], e_sync[2]}) begin
        miscompares++;
        $display("FAIL sync_pipe h=%0d: got sync=%b want %b", h, sync_out, e_sync[2]);
      end
      if (sync_out === 1'b0) begin
        lows++;
        if (first_h < 0) first_h = h;
      end
    end
    vectors++;
    if (lows != 44 || first_h != 2010) begin
      miscompares++;
      $display("FAIL sync_width: got %0d low from h=%0d, want 44 from h=2010", lows, first_h);
    end
  endtask

  task automatic test_reset_mid();
    for (int h = 300; h <= 800; h++) cyc(12'(h), 12'd500, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({rd_addr, rgb_out, de_out, sync_out} !== {17'h0, 24'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_async: got %h/%h/%b/%b want 0/0/0/1", rd_addr, rgb_out, de_out, sync_out);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int v = 501; v <= 1124 + 60; v++) begin
      cyc(12'd1600, 12'(v % 1125), 1'b0, 1'b1);
      vectors++;
      if ($isunknown({rd_addr, rgb_out, de_out, sync_out}) ||
          rd_addr !== e_addr || {rgb_out, de_out, sync_out} !== {e_rgb[2], e_de[2], e_sync[2]}) begin
        miscompares++;
        $display("FAIL midreset_line v=%0d: got %h/%h/%b/%b", v % 1125, rd_addr, rgb_out, de_out, sync_out);
      end
    end
    for (int h = 316; h <= 1603; h++) begin
      cyc(12'(h), 12'd60, 1'b1, 1'b1);
      vectors++;
      if (rd_addr !== e_addr || {rgb_out, de_out, sync_out} !== {e_rgb[2], e_de[2], e_sync[2]}) begin
        miscompares++;
        $display("FAIL midreset_pix h=%0d: got %0d %h want %0d %h", h, rd_addr, rgb_out, e_addr, e_rgb[2]);
      end
      if (h == 320 || h == 324) begin
        vectors++;
        if (rd_addr !== ((h == 324) ? 17'd1 : 17'd0)) begin
          miscompares++;
          $display("FAIL midreset_first h=%0d: got %0d", h, rd_addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_ramp();
    test_pixel();
    test_frame();
    test_sync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
